// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency instruction
// memory over a req/ack handshake, and feeds the decode pipeline register.
// A request, once issued, is never withdrawn. If a redirect arrives while a
// request is still outstanding, the stale response is drained in StDrop.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        StallF,
  input  logic [1:0]  PCSrcD,
  input  logic [31:0] PCBranchD,
  input  logic [31:0] PCJumpD,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemRData,
  output logic [31:0] RD,
  output logic [31:0] PCPlusF,
  output logic        FetchBusyF
);

  typedef enum logic [1:0] {
    StReq  = 2'd0,
    StHold = 2'd1,
    StDrop = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] instr_buf_q, instr_buf_d;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        redirect;

  // Unqualified outputs of the FSM, before the reset override
  logic        req_raw;
  logic [31:0] addr_raw;
  logic [31:0] rd_raw;
  logic        busy_raw;

  // Next-PC selection; jump wins over branch when both are flagged
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    redirect = PCSrcD[1] | PCSrcD[0];
    if (PCSrcD[1]) begin
      next_pc = PCJumpD;
    end else if (PCSrcD[0]) begin
      next_pc = PCBranchD;
    end else begin
      next_pc = pc_plus4;
    end
  end

  // State register, PC and buffers
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StReq;
      pc_q        <= RESET_PC;
      drop_addr_q <= 32'h0000_0000;
      instr_buf_q <= NOP_INSTR;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      instr_buf_q <= instr_buf_d;
    end
  end

  // Next-state logic and raw handshake / decode-side outputs
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    instr_buf_d = instr_buf_q;
    req_raw     = 1'b0;
    addr_raw    = pc_q;
    rd_raw      = NOP_INSTR;
    busy_raw    = 1'b0;

    unique case (state_q)
      StReq: begin
        req_raw  = 1'b1;
        addr_raw = pc_q;
        if (IMemAck) begin
          // Word goes to decode even on a redirect; decode flushes it
          rd_raw = IMemRData;
          if (StallF) begin
            instr_buf_d = IMemRData;
            state_d     = StHold;
          end else begin
            pc_d = next_pc;
          end
        end else begin
          busy_raw = 1'b1;
          if (redirect && !StallF) begin
            // Request for pc_q is already out; remember it so we can drain it
            drop_addr_d = pc_q;
            pc_d        = next_pc;
            state_d     = StDrop;
          end
        end
      end

      StHold: begin
        rd_raw = instr_buf_q;
        if (!StallF) begin
          pc_d    = next_pc;
          state_d = StReq;
        end
      end

      StDrop: begin
        req_raw  = 1'b1;
        addr_raw = drop_addr_q;
        busy_raw = 1'b1;
        // Later redirects retarget the PC; no fall-through increment here
        if (redirect && !StallF) begin
          pc_d = next_pc;
        end
        if (IMemAck) begin
          state_d = StReq;
        end
      end

      default: begin
        state_d = StReq;
      end
    endcase
  end

  // Reset forces the memory side and decode side quiet
  always_comb begin
    PCPlusF = pc_plus4;
    if (Reset) begin
      IMemReq    = 1'b0;
      IMemAddr   = addr_raw;
      RD         = NOP_INSTR;
      FetchBusyF = 1'b0;
    end else begin
      IMemReq    = req_raw;
      IMemAddr   = addr_raw;
      RD         = rd_raw;
      FetchBusyF = busy_raw;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a behavioural memory with configurable wait states and
// a transaction-level model of the fetch stage (pending PC, optional held word,
// optional stale request to drain). Directed scenarios first, then random.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        Reset;
  logic        StallF;
  logic [1:0]  PCSrcD;
  logic [31:0] PCBranchD;
  logic [31:0] PCJumpD;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemRData;
  logic [31:0] RD;
  logic [31:0] PCPlusF;
  logic        FetchBusyF;

  localparam logic [31:0] Nop = 32'h0000_0000;

  fetch_stage dut (
    .clk        (clk),
    .Reset      (Reset),
    .StallF     (StallF),
    .PCSrcD     (PCSrcD),
    .PCBranchD  (PCBranchD),
    .PCJumpD    (PCJumpD),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemAck    (IMemAck),
    .IMemRData  (IMemRData),
    .RD         (RD),
    .PCPlusF    (PCPlusF),
    .FetchBusyF (FetchBusyF)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Memory: wait cycles remaining for the current request; fixed_wait < 0 means random
  int mem_wait   = 0;
  int fixed_wait = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_held_word;
  logic [31:0] m_stale_addr;
  bit          m_holding;
  bit          m_stale;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick_wait();
    if (fixed_wait >= 0) return fixed_wait;
    return int'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    if ($urandom_range(0, 5) == 0) begin
      t = 32'hFFFF_FFFC;
    end else begin
      t = $urandom;
      t[1:0] = 2'b00;
    end
    return t;
  endfunction

  // Entered at a negedge; reset pulse lands mid-low-phase, released on the next negedge
  task automatic apply_reset();
    IMemAck = 1'b0;
    StallF  = 1'b0;
    PCSrcD  = 2'b00;
    #2;
    Reset = 1'b1;
    #1;
    check_eq("rst_req", {31'b0, IMemReq}, 32'd0);
    check_eq("rst_rd", RD, Nop);
    check_eq("rst_busy", {31'b0, FetchBusyF}, 32'd0);
    check_eq("rst_pcplus", PCPlusF, 32'd4);
    m_pc         = 32'h0;
    m_held_word  = Nop;
    m_stale_addr = 32'h0;
    m_holding    = 1'b0;
    m_stale      = 1'b0;
    @(negedge clk);
    Reset    = 1'b0;
    mem_wait = pick_wait();
  endtask

  // One clock cycle: drive inputs at negedge, let memory answer, check, advance model
  task automatic do_cycle(input bit st, input logic [1:0] src,
                          input logic [31:0] br, input logic [31:0] jp);
    logic [31:0] tgt;
    logic [31:0] e_addr;
    logic [31:0] e_rd;
    bit          e_req;
    bit          e_busy;
    bit          ack;
    bit          redir;

    StallF    = st;
    PCSrcD    = src;
    PCBranchD = br;
    PCJumpD   = jp;
    #1;
    ack       = IMemReq && (mem_wait == 0);
    IMemAck   = ack;
    IMemRData = ack ? IMemAddr + 32'h100 : 32'hDEAD_BEEF;
    #1;

    redir = (src != 2'b00);
    tgt   = src[1] ? jp : (src[0] ? br : m_pc + 32'd4);

    if (m_stale) begin
      e_req = 1'b1; e_addr = m_stale_addr; e_rd = Nop; e_busy = 1'b1;
    end else if (m_holding) begin
      e_req = 1'b0; e_addr = 32'h0; e_rd = m_held_word; e_busy = 1'b0;
    end else begin
      e_req  = 1'b1;
      e_addr = m_pc;
      e_rd   = ack ? m_pc + 32'h100 : Nop;
      e_busy = !ack;
    end

    check_eq("req", {31'b0, IMemReq}, {31'b0, e_req});
    if (e_req) check_eq("addr", IMemAddr, e_addr);
    check_eq("rd", RD, e_rd);
    check_eq("busy", {31'b0, FetchBusyF}, {31'b0, e_busy});
    check_eq("pcplus", PCPlusF, m_pc + 32'd4);

    if (m_stale) begin
      if (redir && !st) m_pc = tgt;
      if (ack) m_stale = 1'b0;
    end else if (m_holding) begin
      if (!st) begin
        m_pc      = tgt;
        m_holding = 1'b0;
      end
    end else if (ack) begin
      if (st) begin
        m_held_word = e_rd;
        m_holding   = 1'b1;
      end else begin
        m_pc = tgt;
      end
    end else if (redir && !st) begin
      m_stale_addr = m_pc;
      m_stale      = 1'b1;
      m_pc         = tgt;
    end

    if (ack) mem_wait = pick_wait();
    else if (IMemReq && mem_wait > 0) mem_wait--;

    @(negedge clk);
  endtask

  initial begin
    Reset     = 1'b1;
    StallF    = 1'b0;
    PCSrcD    = 2'b00;
    PCBranchD = 32'h0;
    PCJumpD   = 32'h0;
    IMemAck   = 1'b0;
    IMemRData = 32'h0;
    @(negedge clk);

    // Zero-wait streaming
    fixed_wait = 0;
    apply_reset();
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 2'b00, 32'h0, 32'h0);

    // Two wait cycles per request
    fixed_wait = 2;
    apply_reset();
    for (int i = 0; i < 6; i++) do_cycle(1'b0, 2'b00, 32'h0, 32'h0);

    // Stall in the ack cycle of addr 8, released three cycles later
    fixed_wait = 0;
    apply_reset();
    do_cycle(1'b0, 2'b00, 32'h0, 32'h0);
    do_cycle(1'b0, 2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 2'b00, 32'h0, 32'h0);

    // Branch, then jump+branch together (jump wins)
    apply_reset();
    do_cycle(1'b0, 2'b01, 32'h40, 32'h0);
    do_cycle(1'b0, 2'b11, 32'h40, 32'h80);
    do_cycle(1'b0, 2'b00, 32'h0, 32'h0);
    do_cycle(1'b0, 2'b10, 32'h0, 32'hFFFF_FFFC);
    do_cycle(1'b0, 2'b00, 32'h0, 32'h0);

    // Branch while the request for 0x10 sits in three wait cycles
    apply_reset();
    fixed_wait = 3;
    do_cycle(1'b0, 2'b10, 32'h0, 32'h10);
    do_cycle(1'b0, 2'b01, 32'h40, 32'h0);
    for (int i = 0; i < 6; i++) do_cycle(1'b0, 2'b00, 32'h0, 32'h0);

    // Reset in the middle of a wait
    fixed_wait = 3;
    apply_reset();
    do_cycle(1'b0, 2'b00, 32'h0, 32'h0);
    do_cycle(1'b0, 2'b00, 32'h0, 32'h0);
    fixed_wait = 0;
    apply_reset();
    do_cycle(1'b0, 2'b00, 32'h0, 32'h0);
    do_cycle(1'b0, 2'b00, 32'h0, 32'h0);

    // Random traffic: wait states, stalls, redirects, occasional reset
    fixed_wait = -1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        apply_reset();
      end else begin
        logic [1:0] src;
        src = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        do_cycle($urandom_range(0, 3) == 0, src, pick_target(), pick_target());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
